// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master port among NUM_REQ
// CPU-side requesters, with a watchdog that aborts transfers the slave never
// completes.
module apb_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              req_wr,
    input  logic [NUM_REQ-1:0]              req_strb,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [NUM_REQ-1:0]              done,
    output logic                            rsp_err,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            m_trnsfr,
    output logic                            m_wr,
    output logic                            m_strb,
    output logic [ADDR_WIDTH-1:0]           m_address,
    output logic [DATA_WIDTH-1:0]           m_data_in,
    input  logic [DATA_WIDTH-1:0]           m_data_out,
    input  logic                            apb_sel,
    input  logic                            apb_enable,
    input  logic                            apb_ready,
    input  logic                            apb_slverr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT - 1);
    // The abort decision is taken one cycle before the count reaches
    // TIMEOUT-1, so that the registered done lands TIMEOUT cycles after the
    // transfer strobe.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [PTR_W-1:0]           r_ptr;
    logic [PTR_W-1:0]           r_win;
    logic [WD_W-1:0]            r_wd;
    logic [NUM_REQ-1:0]         r_gnt;
    logic [NUM_REQ-1:0]         r_done;
    logic                       r_rspErr;
    logic [DATA_WIDTH-1:0]      r_rspRdata;
    logic                       r_mWr;
    logic                       r_mStrb;
    logic [ADDR_WIDTH-1:0]      r_mAddr;
    logic [DATA_WIDTH-1:0]      r_mData;

    logic [2*NUM_REQ-1:0]       w_reqDbl;
    logic [PTR_W-1:0]           w_winIdx;
    logic                       w_any;
    logic                       w_complete;
    logic                       w_timeout;
    logic                       w_finish;

    assign w_reqDbl   = {req, req};
    assign w_any      = |req;
    assign w_complete = apb_sel & apb_enable & apb_ready;
    assign w_timeout  = (r_wd == WD_LAST);
    assign w_finish   = (r_state == WAIT) & (w_complete | w_timeout);

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rspRdata;
    assign m_trnsfr  = (r_state == ISSUE);
    assign m_wr      = r_mWr;
    assign m_strb    = r_mStrb;
    assign m_address = r_mAddr;
    assign m_data_in = r_mData;

    // Round-robin pick: lowest set bit of the doubled request vector above the last winner.
    always_comb begin
        w_winIdx = '0;
        for (int j = 2*NUM_REQ-1; j >= 0; j--) begin
            if (w_reqDbl[j] && (j > int'(r_ptr))) begin
                w_winIdx = (j >= NUM_REQ) ? PTR_W'(j - NUM_REQ) : PTR_W'(j);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: arbitrate, strobe for one cycle, then wait for completion or abort.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (w_finish) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant, command latch, watchdog and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr      <= PTR_W'(NUM_REQ - 1);
            r_win      <= '0;
            r_wd       <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
            r_mWr      <= 1'b0;
            r_mStrb    <= 1'b0;
            r_mAddr    <= '0;
            r_mData    <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_win   <= w_winIdx;
                        r_gnt   <= NUM_REQ'(1) << w_winIdx;
                        r_mWr   <= req_wr[w_winIdx];
                        r_mStrb <= req_strb[w_winIdx];
                        r_mAddr <= req_addr[int'(w_winIdx)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mData <= req_wdata[int'(w_winIdx)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ISSUE: begin
                    r_wd <= '0;
                end
                WAIT: begin
                    if (r_wd != WD_MAX) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                    if (w_complete) begin
                        r_done   <= r_gnt;
                        r_rspErr <= apb_slverr;
                        if (!r_mWr) begin
                            r_rspRdata <= m_data_out;
                        end
                    end else if (w_timeout) begin
                        r_done   <= r_gnt;
                        r_rspErr <= 1'b1;
                    end
                    if (w_finish) begin
                        r_gnt <= '0;
                        r_ptr <= r_win;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
